acc_reduce: RTL and testbench

ACC_REDUCE -- requirements
Module: acc_reduce

---
 rtl/acc_reduce_pkg.sv | 22 ++
 rtl/acc_reduce_if.sv | 11 +
 rtl/acc_reduce.sv | 80 ++++++++
 tb/tb_acc_reduce.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_reduce_pkg.sv
// rtl/acc_reduce_pkg.sv - shared stream stage types and defaults for acc_reduce
package acc_reduce_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_LEN   = 4;

   typedef enum logic {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } state_t;

   typedef struct packed {
      logic req;
      logic ack;
   } hs_t;

   // Counter must be able to hold LEN itself, hence LEN+1 states.
   function automatic int cnt_bits(input int len);
      return (len < 1) ? 1 : $clog2(len + 1);
   endfunction

endpackage

// File: rtl/acc_reduce_if.sv
// rtl/acc_reduce_if.sv - req/ack word stream used on both sides of acc_reduce
interface acc_reduce_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] dat;
   logic             req;
   logic             ack;

   modport master (output dat, output req, input ack);
   modport slave  (input dat, input req, output ack);
endinterface

// File: rtl/acc_reduce.sv
// rtl/acc_reduce.sv - sums each group of LEN input words into one output word
module acc_reduce
   import acc_reduce_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LEN   = DEF_LEN
) (
   input  logic         clk,
   input  logic         reset,
   acc_reduce_if.slave  t_0,
   acc_reduce_if.master i_0
);

   localparam int            CW   = cnt_bits(LEN);
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             t_ack;
   logic             o_req;
   logic             in_xfer;
   logic             out_xfer;

   // t_ack follows i_0.ack while a sum is held so a new group can start
   // in the same cycle the finished sum leaves.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      o_req    = (state_q == EMIT);
      t_ack    = (state_q == ACCUM) || i_0.ack;
      in_xfer  = t_0.req && t_ack;
      out_xfer = o_req && i_0.ack;

      unique case (state_q)
         ACCUM: begin
            if (in_xfer) begin
               acc_d = (cnt_q == '0) ? t_0.dat : acc_q + t_0.dat;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = EMIT;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
         end
         EMIT: begin
            if (out_xfer) begin
               if (in_xfer) begin
                  acc_d   = t_0.dat;
                  cnt_d   = ONE;
                  state_d = (LEN == 1) ? EMIT : ACCUM;
               end else begin
                  cnt_d   = '0;
                  state_d = ACCUM;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   assign t_0.ack = t_ack;
   assign i_0.req = o_req;
   assign i_0.dat = acc_q;

endmodule

// File: tb/tb_acc_reduce.sv
// tb/tb_acc_reduce.sv - scoreboard bench for acc_reduce with LEN 4, 1 and 3
module tb_acc_reduce;

   logic clk;
   logic reset;

   acc_reduce_if #(.WIDTH(32)) t4 ();
   acc_reduce_if #(.WIDTH(32)) i4 ();
   acc_reduce_if #(.WIDTH(32)) t1 ();
   acc_reduce_if #(.WIDTH(32)) i1 ();
   acc_reduce_if #(.WIDTH(32)) t3 ();
   acc_reduce_if #(.WIDTH(32)) i3 ();

   acc_reduce #(.WIDTH(32), .LEN(4)) u4 (.clk(clk), .reset(reset), .t_0(t4), .i_0(i4));
   acc_reduce #(.WIDTH(32), .LEN(1)) u1 (.clk(clk), .reset(reset), .t_0(t1), .i_0(i1));
   acc_reduce #(.WIDTH(32), .LEN(3)) u3 (.clk(clk), .reset(reset), .t_0(t3), .i_0(i3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        treq;
      logic        tack;
      logic        ireq;
      logic        iack;
      logic [31:0] tdat;
      logic [31:0] idat;
   } snap_t;

   int          total = 0;
   int          bad   = 0;
   int          lens[3] = '{4, 1, 3};
   logic [31:0] words[3][$];
   logic [31:0] expq[3][$];
   int          npop[3] = '{0, 0, 0};
   bit          rnd_done = 1'b0;

   function automatic snap_t snap(input int w);
      snap_t s;
      case (w)
         0:       s = '{t4.req, t4.ack, i4.req, i4.ack, t4.dat, i4.dat};
         1:       s = '{t1.req, t1.ack, i1.req, i1.ack, t1.dat, i1.dat};
         default: s = '{t3.req, t3.ack, i3.req, i3.ack, t3.dat, i3.dat};
      endcase
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic set_t(input int w, input logic r, input logic [31:0] d);
      case (w)
         0:       begin t4.req = r; t4.dat = d; end
         1:       begin t1.req = r; t1.dat = d; end
         default: begin t3.req = r; t3.dat = d; end
      endcase
   endtask

   // Presents d and returns at the negedge before the edge that accepts it.
   task automatic push(input int w, input logic [31:0] d, output int waits);
      bit acc;
      @(posedge clk); #1;
      set_t(w, 1'b1, d);
      waits = 0;
      acc   = 1'b0;
      while (!acc && waits <= 200) begin
         @(negedge clk);
         if (snap(w).tack) acc = 1'b1;
         else waits++;
      end
      if (!acc) chk($sformatf("push%0d_timeout", w), 32'd0, 32'd1);
   endtask

   task automatic idle(input int w);
      @(posedge clk); #1;
      set_t(w, 1'b0, $urandom);
   endtask

   // Reference model: collect accepted words, every LEN of them yields their sum.
   always @(negedge clk) begin : model
      snap_t       s;
      logic [31:0] sum;
      for (int w = 0; w < 3; w++) begin
         s = snap(w);
         if (reset) begin
            words[w].delete();
            expq[w].delete();
         end else if (s.treq && s.tack) begin
            words[w].push_back(s.tdat);
            if (words[w].size() == lens[w]) begin
               sum = 32'd0;
               for (int k = 0; k < words[w].size(); k++) sum = sum + words[w][k];
               expq[w].push_back(sum);
               words[w].delete();
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      snap_t       s;
      logic [31:0] e;
      if (!reset) begin
         for (int w = 0; w < 3; w++) begin
            s = snap(w);
            if (s.ireq && s.iack) begin
               if (expq[w].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL out%0d_spurious: got %0h want no output", w, s.idat);
               end else begin
                  e = expq[w].pop_front();
                  chk($sformatf("out%0d_sum", w), s.idat, e);
                  npop[w]++;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int    wt;
      int    wsum;
      int    n;
      snap_t s;

      reset = 1'b1;
      set_t(0, 1'b0, 32'd0);
      set_t(1, 1'b0, 32'd0);
      set_t(2, 1'b0, 32'd0);
      i4.ack = 1'b1;
      i1.ack = 1'b1;
      i3.ack = 1'b1;

      @(posedge clk); #1;
      for (int w = 0; w < 3; w++) begin
         s = snap(w);
         chk($sformatf("rst%0d_ireq", w), {31'd0, s.ireq}, 32'd0);
         chk($sformatf("rst%0d_idat", w), s.idat, 32'd0);
         chk($sformatf("rst%0d_tack", w), {31'd0, s.tack}, 32'd1);
      end
      @(posedge clk); #1;
      reset = 1'b0;

      // 1,2,3,4 -> 10, one cycle after the 4th acceptance
      for (int k = 1; k <= 4; k++) push(0, k, wt);
      chk("l4_req_before", {31'd0, i4.req}, 32'd0);
      @(posedge clk); #1;
      set_t(0, 1'b0, 32'd0);
      chk("l4_req_after", {31'd0, i4.req}, 32'd1);
      chk("l4_dat_10", i4.dat, 32'd10);
      @(posedge clk); #1;
      chk("l4_req_gone", {31'd0, i4.req}, 32'd0);

      // eight all-ones words, no bubble between groups
      wsum = 0;
      for (int k = 0; k < 8; k++) begin
         push(0, 32'hFFFF_FFFF, wt);
         wsum += wt;
      end
      chk("l4_no_bubble", wsum, 32'd0);
      idle(0);
      idle(0);

      // downstream stall holds the sum and the 5th word
      i4.ack = 1'b0;
      for (int k = 1; k <= 4; k++) push(0, k, wt);
      @(posedge clk); #1;
      set_t(0, 1'b1, 32'd5);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_dat", i4.dat, 32'd10);
         chk("stall_tack", {31'd0, t4.ack}, 32'd0);
         chk("stall_ireq", {31'd0, i4.req}, 32'd1);
         @(posedge clk); #1;
      end
      i4.ack = 1'b1;
      @(negedge clk);
      chk("stall_release", {31'd0, t4.ack}, 32'd1);
      for (int k = 6; k <= 8; k++) push(0, k, wt);
      idle(0);
      idle(0);
      idle(0);

      // LEN=1 passthrough, one cycle delayed, back to back
      @(posedge clk); #1;
      set_t(1, 1'b1, 32'd7);
      for (int k = 7; k <= 9; k++) begin
         @(posedge clk); #1;
         chk("l1_req", {31'd0, i1.req}, 32'd1);
         chk("l1_dat", i1.dat, k);
         if (k < 9) set_t(1, 1'b1, k + 1);
         else       set_t(1, 1'b0, 32'd0);
      end
      @(posedge clk); #1;
      chk("l1_req_gone", {31'd0, i1.req}, 32'd0);

      // reset mid-group discards 5,6
      push(0, 32'd5, wt);
      push(0, 32'd6, wt);
      @(posedge clk); #1;
      set_t(0, 1'b0, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_ireq", {31'd0, i4.req}, 32'd0);
      chk("mid_rst_idat", i4.dat, 32'd0);
      chk("mid_rst_tack", {31'd0, t4.ack}, 32'd1);
      for (int k = 0; k < 4; k++) push(0, 32'd1, wt);
      @(posedge clk); #1;
      set_t(0, 1'b0, 32'd0);
      chk("mid_rst_sum4", i4.dat, 32'd4);
      idle(0);

      // LEN=3 random traffic with random downstream stalls
      fork
         begin
            for (int k = 0; k < 1000; k++) begin
               repeat ($urandom_range(0, 2)) idle(2);
               push(2, $urandom, wt);
            end
            idle(2);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               i3.ack = ($urandom_range(0, 3) != 0);
            end
         end
      join
      i3.ack = 1'b1;
      n = 0;
      while (expq[2].size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("l3_drained", expq[2].size(), 32'd0);
      chk("l3_outputs", npop[2], 32'd333);
      chk("l3_leftover", words[2].size(), 32'd1);
      chk("l4_outputs", npop[0], 32'd6);
      chk("l1_outputs", npop[1], 32'd3);
      chk("l4_pending", expq[0].size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
